// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between the RV32I
// core (instruction read, data read, data write) and a host port.
//
// Core priority is dw > dr > ir. The host wins when no core port requests, or
// when it has lost HOST_STARVE_LIMIT consecutive cycles; that forced grant
// preempts the core. A core port that requests but is not granted raises
// o_core_stall. The grant and the RAM drive are combinational. Read data
// returns the cycle after the grant, with the same latency as a bare RAM.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   o_core_stall                core must not advance this cycle
//   i_ir_* / o_ir_data          instruction read port
//   i_dr_* / o_dr_data          data read port
//   i_dw_*                      data write port
//   i_host_* / o_host_*         host request, accept, read return
//   o_oob_err                   1-cycle pulse after an out-of-range grant
//   o_ram_* / i_ram_rdata       RAM interface
//
// Optional build macro MEM_ARB_STATS_EN adds o_stat_stall_cycles and
// o_stat_host_forced, which are saturating event counters.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH        = 12,
  parameter int unsigned HOST_STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_core_stall,
  input  logic                  i_ir_en,
  input  logic [31:0]           i_ir_addr,
  output logic [31:0]           o_ir_data,
  input  logic                  i_dr_en,
  input  logic [31:0]           i_dr_addr,
  output logic [31:0]           o_dr_data,
  input  logic                  i_dw_en,
  input  logic [31:0]           i_dw_addr,
  input  logic [31:0]           i_dw_data,
  input  logic                  i_host_valid,
  input  logic                  i_host_we,
  input  logic [31:0]           i_host_addr,
  input  logic [31:0]           i_host_wdata,
  output logic                  o_host_ready,
  output logic                  o_host_rvalid,
  output logic [31:0]           o_host_rdata,
  output logic                  o_oob_err,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]           o_ram_wdata,
  input  logic [31:0]           i_ram_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           o_stat_stall_cycles,
  output logic [15:0]           o_stat_host_forced
`endif
);

  localparam int unsigned STARVE_W  = 8;
  localparam int unsigned OOB_SHIFT = ADDR_WIDTH + 2;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(HOST_STARVE_LIMIT);

  localparam logic [1:0] TAG_IR   = 2'd0;
  localparam logic [1:0] TAG_DR   = 2'd1;
  localparam logic [1:0] TAG_HOST = 2'd2;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_DW,
    SRC_DR,
    SRC_IR,
    SRC_HOST
  } src_e;

  src_e                w_src;
  logic                w_forced;
  logic                w_gnt;
  logic                w_oob;
  logic                w_stall;
  logic                w_sel_rd;
  logic                w_sel_we;
  logic [31:0]         w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic [1:0]          w_tag;
  logic [31:0]         w_rdata;
  logic                w_unused_addr_lsb;

  logic                r_pend;
  logic [1:0]          r_tag;
  logic                r_oob;
  logic [STARVE_W-1:0] r_starve;
  logic [31:0]         r_ir_hold;
  logic [31:0]         r_dr_hold;
  logic [31:0]         r_host_hold;

  // Byte-offset bits never reach the word-addressed RAM.
  assign w_unused_addr_lsb = ^{i_ir_addr[1:0], i_dr_addr[1:0],
                               i_dw_addr[1:0], i_host_addr[1:0]};

  // A host that has lost the limit number of cycles takes the RAM outright.
  assign w_forced = i_host_valid && (r_starve == STARVE_MAX);

  // Grant selection: forced host, then dw > dr > ir, then an idle-core host.
  always_comb begin
    w_src = SRC_NONE;
    if (w_forced)          w_src = SRC_HOST;
    else if (i_dw_en)      w_src = SRC_DW;
    else if (i_dr_en)      w_src = SRC_DR;
    else if (i_ir_en)      w_src = SRC_IR;
    else if (i_host_valid) w_src = SRC_HOST;
  end

  // Mux the granted request onto a common access description.
  always_comb begin
    w_sel_rd    = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_tag       = TAG_IR;
    case (w_src)
      SRC_DW: begin
        w_sel_we    = 1'b1;
        w_sel_addr  = i_dw_addr;
        w_sel_wdata = i_dw_data;
      end
      SRC_DR: begin
        w_sel_rd   = 1'b1;
        w_sel_addr = i_dr_addr;
        w_tag      = TAG_DR;
      end
      SRC_IR: begin
        w_sel_rd   = 1'b1;
        w_sel_addr = i_ir_addr;
        w_tag      = TAG_IR;
      end
      SRC_HOST: begin
        w_sel_rd    = !i_host_we;
        w_sel_we    = i_host_we;
        w_sel_addr  = i_host_addr;
        w_sel_wdata = i_host_wdata;
        w_tag       = TAG_HOST;
      end
      default: ;
    endcase
  end

  assign w_gnt = (w_src != SRC_NONE);
  assign w_oob = w_gnt && ((w_sel_addr >> OOB_SHIFT) != '0);

  // An out-of-range grant still counts as a grant but never touches the RAM.
  assign o_ram_en    = w_gnt && !w_oob;
  assign o_ram_we    = o_ram_en && w_sel_we;
  assign o_ram_addr  = o_ram_en ? w_sel_addr[ADDR_WIDTH+1:2] : '0;
  assign o_ram_wdata = o_ram_we ? w_sel_wdata : '0;

  assign w_stall = (i_dw_en && (w_src != SRC_DW)) ||
                   (i_dr_en && (w_src != SRC_DR)) ||
                   (i_ir_en && (w_src != SRC_IR));

  assign o_core_stall = w_stall;
  assign o_host_ready = (w_src == SRC_HOST);

  // Returning read data; an out-of-range read returns zero.
  assign w_rdata = r_oob ? 32'd0 : i_ram_rdata;

  assign o_ir_data     = (r_pend && r_tag == TAG_IR)   ? w_rdata : r_ir_hold;
  assign o_dr_data     = (r_pend && r_tag == TAG_DR)   ? w_rdata : r_dr_hold;
  assign o_host_rdata  = (r_pend && r_tag == TAG_HOST) ? w_rdata : r_host_hold;
  assign o_host_rvalid = r_pend && (r_tag == TAG_HOST);
  assign o_oob_err     = r_oob;

  // Read tracking, hold registers and host starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_tag       <= TAG_IR;
      r_oob       <= 1'b0;
      r_starve    <= '0;
      r_ir_hold   <= '0;
      r_dr_hold   <= '0;
      r_host_hold <= '0;
    end else begin
      r_pend <= w_gnt && w_sel_rd;
      r_tag  <= w_tag;
      r_oob  <= w_oob;

      if (!i_host_valid || o_host_ready) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_MAX) begin
        r_starve <= r_starve + STARVE_W'(1);
      end

      if (r_pend && r_tag == TAG_IR)   r_ir_hold   <= w_rdata;
      if (r_pend && r_tag == TAG_DR)   r_dr_hold   <= w_rdata;
      if (r_pend && r_tag == TAG_HOST) r_host_hold <= w_rdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_stall;
  logic [15:0] r_stat_forced;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_stall  <= '0;
      r_stat_forced <= '0;
    end else begin
      if (w_stall && (r_stat_stall != '1))   r_stat_stall  <= r_stat_stall + 32'd1;
      if (w_forced && (r_stat_forced != '1)) r_stat_forced <= r_stat_forced + 16'd1;
    end
  end

  assign o_stat_stall_cycles = r_stat_stall;
  assign o_stat_host_forced  = r_stat_forced;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between the RV32I core's instruction-read, data-read and data-write ports and one host port (program loader / debugger).
- Resolves conflicts by fixed priority plus a host starvation limit, and freezes the core through core_stall, which drives the core's clk_enable low.
- Sits between the core and the unified RAM; read latency matches a bare RAM, so an unstalled core runs at full speed.

Parameters:
ADDR_WIDTH, 12, RAM word-address width; RAM depth is 2^ADDR_WIDTH words.
HOST_STARVE_LIMIT, 8, consecutive cycles a host request may lose to the core before it is forced through; 1..255.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
core_stall  out  1  high means the core must not advance this cycle
ir_en  in  1  core instruction read enable
ir_addr  in  32  core instruction byte address
ir_data  out  32  instruction read data
dr_en  in  1  core data read enable
dr_addr  in  32  core data read byte address
dr_data  out  32  data read data
dw_en  in  1  core data write enable
dw_addr  in  32  core data write byte address
dw_data  in  32  core data write data
host_valid  in  1  host request
host_we  in  1  host write (1) / read (0)
host_addr  in  32  host byte address
host_wdata  in  32  host write data
host_ready  out  1  host request accepted this cycle
host_rvalid  out  1  host read data valid (1-cycle pulse)
host_rdata  out  32  host read data
oob_err  out  1  1-cycle pulse: granted access fell outside RAM range
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after a read

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. On reset, all registered state clears: pending-read tags, held read data (ir/dr/host = 0), starve counter = 0. host_rvalid and oob_err are 0 in the first cycle after reset.
- Reset mid-read: the read is discarded and no host_rvalid is produced.
- Grant and RAM drive: one grant per cycle, combinational. ram_* is driven directly from the granted request.
- Idle RAM: ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Word address = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored.
- Core priority: dw > dr > ir.
- Host priority: the host is granted when no core port requests, or when the starve counter equals HOST_STARVE_LIMIT. A forced grant preempts all core ports.
- core_stall = 1 whenever any asserted core port is not granted this cycle, else 0. Stalled core requests remain asserted because the core is frozen.
- Starve counter:
  - increments each cycle host_valid is high and not granted, saturating at the limit;
  - clears on host grant or when host_valid is low.
- host_ready = host grant this cycle. Each ready accepts exactly one transfer.
- Read return: a granted read records a 2-bit tag (IR/DR/HOST) and sets pending for the next cycle.
  - In that next cycle the tagged output equals ram_rdata combinationally and is also captured into that port's hold register.
  - In every other cycle the output shows the hold register. Data therefore stays stable until that port's next read.
- host_rvalid pulses high in the ram_rdata cycle of a host read.
- Out-of-range: a granted access with addr[31:ADDR_WIDTH+2] != 0 leaves ram_en low and pulses oob_err the next cycle.
  - An out-of-range write is dropped.
  - An out-of-range read returns 0 through the normal return path; host_rvalid still pulses for host reads.
- Back-to-back: a new grant may issue in the same cycle a previous read's data returns. There is no bubble.
- Simultaneous core write and host write to the same address: the one granted first is written first. The forced host write followed by the core write leaves the core data in RAM.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds the following outputs, cleared by reset:
  - stat_stall_cycles, 32-bit saturating count of cycles with core_stall = 1;
  - stat_host_forced, 16-bit saturating count of forced host grants.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Core-only read: ir_en = 1, ir_addr = 0x10, RAM word 4 = 0x00500093 → ram_addr = 4 the same cycle; ir_data = 0x00500093 next cycle and held after ir_en drops; core_stall never 1.
- Core vs host: dr_en = 1 and host_valid = 1 (read, 0x20) together for 3 cycles → dr granted each cycle; host_ready = 0; core_stall = 0; host granted in the first cycle dr_en = 0, with host_rvalid one cycle later.
- Starvation: HOST_STARVE_LIMIT = 4, dw_en held high, host_valid = 1 (write 0xDEADBEEF to 0x40) → host_ready in the 5th cycle, core_stall = 1 only in that cycle; RAM word 16 = 0xDEADBEEF; starve counter back to 0.
- Core port collision: dw_en and ir_en both high → write granted, core_stall = 1; next cycle (dw_en low) the ir read is granted, core_stall = 0.
- Out-of-range: ADDR_WIDTH = 12, host read at 0x00004000 → ram_en = 0; next cycle oob_err = 1, host_rvalid = 1, host_rdata = 0.
- Reset mid-read: host read granted, rst_n = 0 on the next edge → host_rvalid stays 0; ir_data/dr_data/host_rdata = 0; core_stall = 0.
